// File: rtl/fifo_dut.sv
// Synchronous single-clock FIFO with registered status, data and error flags.
// Define FIFO_DUT_STICKY_FLAGS_EN to make under_flow/over_flow hold until reset.
module fifo_dut #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_n,
  input  logic                  rd_n,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  under_flow,
  output logic                  over_flow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_acc, wr_acc, under_req, over_req;

  // A read on a full FIFO frees the slot the simultaneous write needs.
  always_comb begin
    rd_acc    = !rd_n && !empty;
    wr_acc    = !wr_n && (!full || rd_acc);
    under_req = !rd_n && empty;
    over_req  = !wr_n && full && !rd_acc;
    count_d   = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout       <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      under_flow <= 1'b0;
      over_flow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout     <= mem[rd_ptr_q];
      end
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
`ifdef FIFO_DUT_STICKY_FLAGS_EN
      under_flow <= under_flow | under_req;
      over_flow  <= over_flow | over_req;
`else
      under_flow <= under_req;
      over_flow  <= over_req;
`endif
    end
  end

  // Storage is deliberately not reset; stale words are unreachable via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_fifo_dut.sv
// Directed self-checking bench for fifo_dut (default 8-bit x 16-word build).
module tb_fifo_dut;

`ifdef FIFO_DUT_STICKY_FLAGS_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_n, rd_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, under_flow, over_flow;
  int         n_checks = 0;
  int         n_fail   = 0;

  fifo_dut #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .din       (din),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .under_flow(under_flow),
    .over_flow (over_flow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given request; outputs are sampled 1 time unit later.
  task automatic step(input bit w, input logic [7:0] d, input bit r);
    wr_n = !w;
    rd_n = !r;
    din  = d;
    @(posedge clk);
    #1;
    wr_n = 1'b1;
    rd_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
    din  = '0;

    // Reset state is visible before any clock edge.
    #2;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_uflow", 32'(under_flow), 0);
    check("rst_oflow", 32'(over_flow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read from empty.
    step(0, 8'h00, 1);
    check("uf_set", 32'(under_flow), 1);
    check("uf_dout", 32'(dout), 0);
    check("uf_empty", 32'(empty), 1);
    step(0, 8'h00, 0);
    check("uf_next", 32'(under_flow), 32'(STICKY));
    step(0, 8'h00, 0);
    check("uf_next2", 32'(under_flow), 32'(STICKY));
    do_reset();
    check("uf_cleared", 32'(under_flow), 0);

    // Three writes then three reads.
    step(1, 8'h11, 0);
    check("w1_empty", 32'(empty), 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(0, 8'h00, 1);
    check("r1_dout", 32'(dout), 32'h11);
    step(0, 8'h00, 1);
    check("r2_dout", 32'(dout), 32'h22);
    step(0, 8'h00, 1);
    check("r3_dout", 32'(dout), 32'h33);
    check("r3_empty", 32'(empty), 1);

    // Fill, overflow, drain.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0);
      check("fill_full", 32'(full), 32'(i == 15));
    end
    check("fill_empty", 32'(empty), 0);
    step(1, 8'hAA, 0);
    check("of_set", 32'(over_flow), 1);
    check("of_full", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1);
      check("drain_dout", 32'(dout), 32'(i));
      if (i == 0) check("of_next", 32'(over_flow), 32'(STICKY));
      check("drain_full", 32'(full), 0);
    end
    check("drain_empty", 32'(empty), 1);

    // Full with simultaneous read and write.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'h5A, 1);
    check("rw_dout", 32'(dout), 32'h00);
    check("rw_full", 32'(full), 1);
    check("rw_oflow", 32'(over_flow), 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 8'h00, 1);
      check("rw_drain", 32'(dout), (i < 15) ? 32'(i + 1) : 32'h5A);
    end
    check("rw_empty", 32'(empty), 1);

    // Empty with simultaneous read and write: read rejected, write kept.
    do_reset();
    step(1, 8'h3C, 1);
    check("ew_uflow", 32'(under_flow), 1);
    check("ew_empty", 32'(empty), 0);
    check("ew_dout", 32'(dout), 0);
    step(0, 8'h00, 1);
    check("ew_read", 32'(dout), 32'h3C);
    check("ew_empty2", 32'(empty), 1);

    // 40 write/read pairs wrap both pointers twice.
    do_reset();
    for (int v = 0; v < 40; v++) begin
      step(1, 8'(v), 0);
      step(0, 8'h00, 1);
      check("wrap_dout", 32'(dout), 32'(v));
    end
    check("wrap_empty", 32'(empty), 1);

    // Asynchronous reset with data stored.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0);
    step(0, 8'h00, 1);
    check("ar_pre_dout", 32'(dout), 32'h40);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_empty", 32'(empty), 1);
    check("ar_dout", 32'(dout), 0);
    check("ar_full", 32'(full), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);
    check("ar_first", 32'(dout), 32'h77);
    check("ar_empty2", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_dut.md
FIFO_DUT -- requirements
Module: fifo_dut

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of din/dout and of each storage word.
REQ-002 Parameter DEPTH, default 16, number of storage words; power of two, at least 2.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 wr_n  input  1  active-low write enable.
REQ-007 rd_n  input  1  active-low read enable.
REQ-008 din  input  DATA_WIDTH  write data.
REQ-009 dout  output  DATA_WIDTH  read data, registered.
REQ-010 full  output  1  high when DEPTH words are stored.
REQ-011 empty  output  1  high when 0 words are stored.
REQ-012 under_flow  output  1  read attempted while empty.
REQ-013 over_flow  output  1  write attempted while full with no accepted read.

Function
REQ-014 Write accepted when wr_n=0 and (full=0, or a read is accepted in the same cycle): din stored at write pointer; pointer advances modulo DEPTH.
REQ-015 Read accepted when rd_n=0 and empty=0: word at read pointer is loaded into dout at that edge (1-cycle latency); pointer advances modulo DEPTH.
REQ-016 dout SHALL hold its last value when no read is accepted, including on underflow.
REQ-017 Occupancy count is 0..DEPTH, held in clog2(DEPTH)+1 bits: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-018 full and empty SHALL be registered and derived from the count; they SHALL never be high together.
REQ-019 When full, wr_n=0 and rd_n=0: both the read and the write are accepted, the count stays DEPTH, and over_flow is not raised.
REQ-020 When empty, wr_n=0 and rd_n=0: the read is rejected and under_flow is raised; the write is accepted and the count becomes 1.
REQ-021 Rejected operations SHALL NOT change the pointers, the count, the memory, or dout.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 with no data loss or reordering; ordering is strictly first-in, first-out.
REQ-023 under_flow and over_flow SHALL be registered and asserted on the edge that samples the offending request.

Reset
REQ-024 While rst=1: pointers=0, count=0, dout=0, empty=1, full=0, under_flow=0, over_flow=0, taking effect immediately without waiting for a clock edge.
REQ-025 Memory contents are not cleared by reset; they are unreachable until rewritten.
REQ-026 Reset asserted mid-operation SHALL discard all stored data; the first accepted write after release is read back first.

Configuration
REQ-027 With FIFO_DUT_STICKY_FLAGS_EN defined, under_flow and over_flow SHALL stay high once set, until rst.
REQ-028 Without FIFO_DUT_STICKY_FLAGS_EN, each flag SHALL be high for exactly one cycle per offending request and return low the next cycle unless the offence repeats.

Verification
REQ-029 Reset, then write 0x11,0x22,0x33 and read three times -> dout 0x11,0x22,0x33, each one edge after its read; empty=1 afterwards.
REQ-030 Write 16 words 0x00..0x0F -> full=1; a 17th write of 0xAA -> over_flow=1 and the data is dropped; 16 reads return 0x00..0x0F.
REQ-031 Read after reset -> under_flow=1 and dout stays 0; with sticky flags the flag stays 1 until rst, otherwise it drops the next cycle.
REQ-032 Full FIFO with simultaneous read and write of 0x5A -> the oldest word is output, full stays 1, no flag; the drain order ends with 0x5A.
REQ-033 Loop 40 write/read pairs (values 0..39) -> pointers wrap twice and the read-back sequence equals the write sequence.
REQ-034 Assert rst with 5 words stored -> empty=1, dout=0 immediately; after release, write 0x77 and read -> dout=0x77.
